fetch_sequencer: RTL and testbench

- Controls the IF stage PC and instruction-memory request.
- Selects the next PC from four sources: sequential, branch redirect from EX, jump from ID, and hold for stall/halt.
- Runs the fetch handshake against a variable-latency instruction memory.
- Generates IF/ID write-enable and the IF/ID and ID/EX flushes; owns the core's halt/resume state.

---
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage PC and instruction-fetch control.
//   Selects the next PC (branch > halt > jump > stall > sequential), runs the
//   request/ready handshake against a variable-latency instruction memory,
//   generates the IF/ID write enable and the IF/ID and ID/EX flushes, and owns
//   the core's halt/resume state.
// Optional build macro: BRANCH_DELAY_SLOT_EN (MIPS delay-slot flush rules).
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   i_imem_ready          memory returns the instruction for o_pc this cycle
//   i_stall               load-use hazard: hold PC and IF/ID
//   i_branch_taken/target taken branch resolved in EX
//   i_jump/target         jump decoded in ID
//   i_halt, i_start       halt decoded in ID / resume pulse from debug
//   o_pc, o_next_pc       registered fetch address / o_pc + PC_INC
//   o_imem_req            fetch request (low only in HALT)
//   o_fetch_valid         fetched instruction is to be used
//   o_if_id_write         IF/ID load enable
//   o_flush_if_id/id_ex   pipeline-register clears
//   o_halted, o_state     HALT indicator / RUN=0 WAIT=1 HALT=2
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_imem_ready,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_halt,
  input  logic        i_start,
  output logic [31:0] o_pc,
  output logic [31:0] o_next_pc,
  output logic        o_imem_req,
  output logic        o_fetch_valid,
  output logic        o_if_id_write,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic        o_halted,
  output logic [1:0]  o_state
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]  r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic        r_pend_vld, w_pend_vld_n;
  logic        r_pend_br, w_pend_br_n;   // pending redirect came from a branch
  logic [31:0] r_pend_tgt, w_pend_tgt_n;
  logic        w_jump_eff;
  logic        w_active;

  assign o_next_pc  = r_pc + PC_INC;
  // halt and jump both come from ID; halt wins
  assign w_jump_eff = i_jump & ~i_halt;
  assign w_active   = (r_state != S_HALT);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_pend_vld <= 1'b0;
      r_pend_br  <= 1'b0;
      r_pend_tgt <= 32'd0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_pend_vld <= w_pend_vld_n;
      r_pend_br  <= w_pend_br_n;
      r_pend_tgt <= w_pend_tgt_n;
    end
  end

  // next-state / next-PC
  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_pend_vld_n = r_pend_vld;
    w_pend_br_n  = r_pend_br;
    w_pend_tgt_n = r_pend_tgt;
    case (r_state)
      S_RUN, S_WAIT: begin
        if (i_imem_ready) begin
          w_state_n = S_RUN;
          if (r_pend_vld) begin
            // returned instruction is on the wrong path: drop it, redirect
            w_pc_n       = r_pend_tgt;
            w_pend_vld_n = 1'b0;
            w_pend_br_n  = 1'b0;
            w_pend_tgt_n = 32'd0;
          end else if (i_branch_taken) w_pc_n = i_branch_target;
          else if (i_halt)             w_state_n = S_HALT;
          else if (i_jump)             w_pc_n = i_jump_target;
          else if (!i_stall)           w_pc_n = o_next_pc;
        end else begin
          // o_pc must stay stable while the request is outstanding, so
          // redirects are remembered. Halt is not latched: IF/ID is not
          // written while waiting, so ID keeps presenting the halt.
          w_state_n = S_WAIT;
          if (i_branch_taken) begin
            w_pend_vld_n = 1'b1;
            w_pend_br_n  = 1'b1;
            w_pend_tgt_n = i_branch_target;
          end else if (w_jump_eff && !(r_pend_vld && r_pend_br)) begin
            w_pend_vld_n = 1'b1;
            w_pend_br_n  = 1'b0;
            w_pend_tgt_n = i_jump_target;
          end
        end
      end
      S_HALT: if (i_start) w_state_n = S_RUN;
      default: w_state_n = S_RUN;
    endcase
  end

  // outputs
  always_comb begin
    o_pc          = r_pc;
    o_state       = r_state;
    o_halted      = (r_state == S_HALT);
    o_imem_req    = w_active;
    o_fetch_valid = w_active & i_imem_ready & ~r_pend_vld & ~i_stall;
`ifdef BRANCH_DELAY_SLOT_EN
    // delay slot after a jump executes; a taken branch squashes IF/ID only
    o_flush_if_id = w_active & i_branch_taken;
    o_flush_id_ex = 1'b0;
`else
    o_flush_if_id = w_active & (i_branch_taken | w_jump_eff);
    o_flush_id_ex = w_active & i_branch_taken;
`endif
    o_if_id_write = o_fetch_valid | o_flush_if_id;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_imem_ready = 1'b0, i_stall = 1'b0, i_branch_taken = 1'b0;
  logic        i_jump = 1'b0, i_halt = 1'b0, i_start = 1'b0;
  logic [31:0] i_branch_target = 32'd0, i_jump_target = 32'd0;
  logic [31:0] o_pc, o_next_pc;
  logic        o_imem_req, o_fetch_valid, o_if_id_write, o_flush_if_id;
  logic        o_flush_id_ex, o_halted;
  logic [1:0]  o_state;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset),
    .i_imem_ready(i_imem_ready), .i_stall(i_stall),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_jump(i_jump), .i_jump_target(i_jump_target),
    .i_halt(i_halt), .i_start(i_start),
    .o_pc(o_pc), .o_next_pc(o_next_pc), .o_imem_req(o_imem_req),
    .o_fetch_valid(o_fetch_valid), .o_if_id_write(o_if_id_write),
    .o_flush_if_id(o_flush_if_id), .o_flush_id_ex(o_flush_id_ex),
    .o_halted(o_halted), .o_state(o_state)
  );

  typedef struct packed {
    logic [31:0] pc, next_pc;
    logic req, fv, ifw, fif, fex, halted;
    logic [1:0] st;
  } exp_t;

  typedef struct packed { logic [31:0] tgt; logic is_br; } redir_t;

  exp_t   sb[$];
  redir_t pend[$];   // at most one remembered redirect

  // reference model: architectural view of the fetch unit
  logic [31:0] m_pc;
  bit          m_halt, m_wait;

  int n_checks = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_halt = 0; m_wait = 0; pend.delete();
  endtask

  // drive one cycle of inputs, push the expected outputs, advance the model
  task automatic step(input bit rdy, input bit stl, input bit br, input logic [31:0] bt,
                      input bit jp, input logic [31:0] jt, input bit hl, input bit st);
    exp_t e;
    bit   jeff;
    i_imem_ready = rdy; i_stall = stl; i_branch_taken = br; i_branch_target = bt;
    i_jump = jp; i_jump_target = jt; i_halt = hl; i_start = st;
    jeff = jp && !hl;
    e.pc      = m_pc;
    e.next_pc = m_pc + 32'd4;
    e.req     = !m_halt;
    e.halted  = m_halt;
    e.st      = m_halt ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
    e.fv      = !m_halt && rdy && pend.size() == 0 && !stl;
`ifdef BRANCH_DELAY_SLOT_EN
    e.fif     = !m_halt && br;
    e.fex     = 1'b0;
`else
    e.fif     = !m_halt && (br || jeff);
    e.fex     = !m_halt && br;
`endif
    e.ifw     = e.fv || e.fif;
    sb.push_back(e);
    if (m_halt) begin
      if (st) m_halt = 0;
    end else if (rdy) begin
      m_wait = 0;
      if (pend.size() != 0) begin
        m_pc = pend[0].tgt; pend.delete();
      end else if (br) m_pc = bt;
      else if (hl)     m_halt = 1;
      else if (jp)     m_pc = jt;
      else if (!stl)   m_pc = m_pc + 32'd4;
    end else begin
      m_wait = 1;
      if (br) begin
        pend.delete(); pend.push_back('{tgt: bt, is_br: 1'b1});
      end else if (jeff && !(pend.size() != 0 && pend[0].is_br)) begin
        pend.delete(); pend.push_back('{tgt: jt, is_br: 1'b0});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic seq(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: outputs are presented every cycle out of reset
  always @(negedge clk) begin
    exp_t e;
    if (reset && sb.size() != 0) begin
      e = sb.pop_front();
      chk("o_pc",          o_pc,                 e.pc);
      chk("o_next_pc",     o_next_pc,            e.next_pc);
      chk("o_imem_req",    32'(o_imem_req),      32'(e.req));
      chk("o_fetch_valid", 32'(o_fetch_valid),   32'(e.fv));
      chk("o_if_id_write", 32'(o_if_id_write),   32'(e.ifw));
      chk("o_flush_if_id", 32'(o_flush_if_id),   32'(e.fif));
      chk("o_flush_id_ex", 32'(o_flush_id_ex),   32'(e.fex));
      chk("o_halted",      32'(o_halted),        32'(e.halted));
      chk("o_state",       32'(o_state),         32'(e.st));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc",    o_pc,             32'h0);
    chk("reset_state", 32'(o_state),     32'd0);
    chk("reset_req",   32'(o_imem_req),  32'd1);
    reset = 1'b1;

    // sequential fetch, then a two-cycle stall at 8
    seq(2);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    seq(2);
    // at 0x10: branch beats stall and jump
    step(1, 1, 1, 32'h40, 1, 32'h80, 0, 0);
    // jump to 0x20, then a 3-cycle wait with a jump in the 2nd cycle
    step(1, 0, 0, 0, 1, 32'h20, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h100, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    seq(1);
    // wait: pending branch not replaced by a later jump; jump+halt doesn't latch
    step(0, 0, 1, 32'h200, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h300, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h400, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // halt at 0x30: branch/jump/stall ignored, start resumes at held PC
    step(1, 0, 0, 0, 1, 32'h30, 0, 0);
    step(1, 0, 0, 0, 1, 32'h500, 1, 0);
    for (int k = 0; k < 5; k++) step(1, k[0], 1, 32'h600, 1, 32'h700, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    seq(2);
    // start outside HALT has no effect; PC wrap at 2^32
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    seq(2);

    // reset mid-WAIT with a pending branch
    step(0, 0, 1, 32'h44, 0, 0, 0, 0);
    i_imem_ready = 0; i_branch_taken = 0;
    #2 reset = 1'b0;
    #1;
    chk("async_reset_pc",    o_pc,         32'h0);
    chk("async_reset_state", 32'(o_state), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    seq(3);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, {$urandom_range(0, 32'h3FFF), 2'b00},
           $urandom_range(0, 5) == 0, {$urandom_range(0, 32'h3FFF), 2'b00},
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 1);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++; n_err++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
